// File: rtl/countdown_display.sv
// countdown_display: time-multiplexed three-digit BCD driver for a 7-segment
// display, with leading-zero blanking and a sticky blinking "lost" mode.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   value_three    most-significant BCD digit
//   value_two      middle BCD digit
//   value_one      least-significant BCD digit
//   loose_control  game-lost indication (level or single-cycle pulse)
//   digit_en       one-hot active-high digit enable {three,two,one}, 000 = dark
//   segments       active-low segments {g,f,e,d,c,b,a}
//   frame_done     one-cycle pulse one cycle after each frame end
module countdown_display #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value_three,
  input  logic [3:0] value_two,
  input  logic [3:0] value_one,
  input  logic       loose_control,
  output logic [2:0] digit_en,
  output logic [6:0] segments,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  typedef enum logic [1:0] {
    SEL_THREE = 2'd0,
    SEL_TWO   = 2'd1,
    SEL_ONE   = 2'd2
  } sel_t;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_LOST_ON  = 2'd1,
    ST_LOST_OFF = 2'd2
  } state_t;

  logic [CNT_W-1:0] cnt;
  sel_t             sel;
  state_t           state;
  logic [BLK_W-1:0] blink_cnt;
  logic             lose_pending;
  logic [3:0]       sh_three;
  logic [3:0]       sh_two;
  logic [3:0]       sh_one;

  logic             frame_end_c;
  logic [3:0]       digit_c;
  logic             blank_c;
  logic [2:0]       en_c;
  logic [6:0]       seg_c;

  // BCD to active-low segments; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign frame_end_c = (sel == SEL_ONE) && (cnt == CNT_LAST);

  // Next-cycle display value for the currently selected digit.
  always_comb begin
    digit_c = sh_one;
    blank_c = 1'b0;
    en_c    = 3'b001;
    seg_c   = SEG_DARK;
    case (sel)
      SEL_THREE: begin
        digit_c = sh_three;
        en_c    = 3'b100;
        blank_c = (sh_three == 4'd0);
      end
      SEL_TWO: begin
        digit_c = sh_two;
        en_c    = 3'b010;
        blank_c = (sh_three == 4'd0) && (sh_two == 4'd0);
      end
      default: begin
        digit_c = sh_one;
        en_c    = 3'b001;
        blank_c = 1'b0;
      end
    endcase
    seg_c = decode(digit_c);
    case (state)
      ST_NORMAL: begin
        if (blank_c) begin
          en_c  = 3'b000;
          seg_c = SEG_DARK;
        end
      end
      ST_LOST_ON: begin
      end
      default: begin
        en_c  = 3'b000;
        seg_c = SEG_DARK;
      end
    endcase
  end

  // Scan counter, shadow registers, lost-mode FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      sel          <= SEL_THREE;
      state        <= ST_NORMAL;
      blink_cnt    <= '0;
      lose_pending <= 1'b0;
      sh_three     <= 4'd0;
      sh_two       <= 4'd0;
      sh_one       <= 4'd0;
      digit_en     <= 3'b000;
      segments     <= SEG_DARK;
      frame_done   <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        case (sel)
          SEL_THREE: sel <= SEL_TWO;
          SEL_TWO:   sel <= SEL_ONE;
          default:   sel <= SEL_THREE;
        endcase
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Latched so a single-cycle pulse is honoured at the next frame end.
      if (loose_control) lose_pending <= 1'b1;

      if (frame_end_c) begin
        sh_three <= value_three;
        sh_two   <= value_two;
        sh_one   <= value_one;
        case (state)
          ST_NORMAL: begin
            if (lose_pending) begin
              state     <= ST_LOST_ON;
              blink_cnt <= '0;
            end
          end
          ST_LOST_ON: begin
            if (blink_cnt == BLK_LAST) begin
              state     <= ST_LOST_OFF;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + BLK_W'(1);
            end
          end
          ST_LOST_OFF: begin
            if (blink_cnt == BLK_LAST) begin
              state     <= ST_LOST_ON;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + BLK_W'(1);
            end
          end
          default: state <= ST_NORMAL;
        endcase
      end

      digit_en   <= en_c;
      segments   <= seg_c;
      frame_done <= frame_end_c;
    end
  end

endmodule
